// File: rtl/cy_cdc_hs_tx_v1_0.sv
// Transmit side of a two-phase toggle req/ack clock-domain crossing.
// Holds an accepted word on data_out, toggles req_out, and waits for the synchronized ack toggle.
module cy_cdc_hs_tx_v1_0 #(
   parameter int unsigned DataWidth     = 8,
   parameter int unsigned SyncStages    = 2,
   parameter int unsigned TimeoutCycles = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DataWidth-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DataWidth-1:0] data_out,
   output logic                 req_out,
   input  logic                 ack_in,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout_err,
   output logic                 proto_err,
   input  logic                 err_clear
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam bit          TO_EN   = (TimeoutCycles != 0);
   localparam logic [15:0] TO_LAST = 16'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SyncStages-1:0]  r_sync;
   logic [DataWidth-1:0]   r_data;
   logic                   r_req;
   logic [15:0]            r_cnt;
   logic                   r_done;
   logic                   r_timeout_err;
   logic                   r_proto_err;

   logic                   w_ack_s;
   logic                   w_ack_match;
   logic                   w_ready;
   logic                   w_accept;
   logic                   w_done_set;
   logic                   w_to_set;
   logic                   w_proto_set;

   assign w_ack_s     = r_sync[SyncStages-1];
   assign w_ack_match = (w_ack_s == r_req);

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_accept    = 1'b0;
      w_done_set  = 1'b0;
      w_to_set    = 1'b0;
      w_proto_set = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready  = !reset;
            w_accept = in_valid && !reset;
            if (w_accept) begin
               w_state_nxt = ST_WAIT;
            end
            // A stray ack toggle is only a protocol error when no word is being launched.
            w_proto_set = !w_ack_match && !w_accept;
         end
         ST_WAIT: begin
            if (w_ack_match) begin
               w_state_nxt = ST_IDLE;
               w_done_set  = 1'b1;
            end else begin
               w_to_set = TO_EN && (r_cnt >= TO_LAST);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_sync        <= '0;
         r_data        <= '0;
         r_req         <= 1'b0;
         r_cnt         <= '0;
         r_done        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_proto_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sync  <= {r_sync[SyncStages-2:0], ack_in};
         r_done  <= w_done_set;
         if (w_accept) begin
            r_data <= in_data;
            r_req  <= ~r_req;
            r_cnt  <= '0;
         end else if (r_state == ST_WAIT && !w_ack_match && r_cnt != '1) begin
            r_cnt <= r_cnt + 16'd1;
         end
         // Sticky flags: a set condition in the same cycle as err_clear wins.
         if (w_to_set) begin
            r_timeout_err <= 1'b1;
         end else if (err_clear) begin
            r_timeout_err <= 1'b0;
         end
         if (w_proto_set) begin
            r_proto_err <= 1'b1;
         end else if (err_clear) begin
            r_proto_err <= 1'b0;
         end
      end
   end

   assign in_ready    = w_ready;
   assign data_out    = r_data;
   assign req_out     = r_req;
   assign busy        = (r_state == ST_WAIT);
   assign done        = r_done;
   assign timeout_err = r_timeout_err;
   assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_cy_cdc_hs_tx_v1_0.sv
// Directed bench for cy_cdc_hs_tx_v1_0: a table-driven single transfer plus hand-written corner sequences.
module tb_cy_cdc_hs_tx_v1_0;

   logic       clk;
   logic       rst;
   logic [7:0] da, db;
   logic       va, vb, acka, ackb, ecla, eclb;
   logic       rdy_a, req_a, busy_a, done_a, terr_a, perr_a;
   logic       rdy_b, req_b, busy_b, done_b, terr_b, perr_b;
   logic [7:0] dout_a, dout_b;

   int n_chk;
   int n_pass;

   cy_cdc_hs_tx_v1_0 #(.DataWidth(8), .SyncStages(2), .TimeoutCycles(10)) dut_a (
      .clock(clk), .reset(rst), .in_data(da), .in_valid(va), .in_ready(rdy_a),
      .data_out(dout_a), .req_out(req_a), .ack_in(acka), .busy(busy_a), .done(done_a),
      .timeout_err(terr_a), .proto_err(perr_a), .err_clear(ecla)
   );

   cy_cdc_hs_tx_v1_0 #(.DataWidth(8), .SyncStages(4), .TimeoutCycles(0)) dut_b (
      .clock(clk), .reset(rst), .in_data(db), .in_valid(vb), .in_ready(rdy_b),
      .data_out(dout_b), .req_out(req_b), .ack_in(ackb), .busy(busy_b), .done(done_b),
      .timeout_err(terr_b), .proto_err(perr_b), .err_clear(eclb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       ack;
      logic       rdy;
      logic       bsy;
      logic       dn;
      logic       req;
      logic [7:0] dout;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; va = 1'b0; vb = 1'b0; acka = 1'b0; ackb = 1'b0; ecla = 1'b0; eclb = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bad;
      int got;
      int edges;

      tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
      tbl[1] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
      tbl[2] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
      tbl[3] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
      tbl[4] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
      tbl[5] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
      tbl[6] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};

      n_chk = 0; n_pass = 0;
      clk = 1'b0; rst = 1'b1;
      da = '0; db = '0; va = 1'b0; vb = 1'b0; acka = 1'b0; ackb = 1'b0; ecla = 1'b0; eclb = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", rdy_a, 0);
      chk("rst_req", req_a, 0);
      chk("rst_dout", dout_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_terr", terr_a, 0);
      chk("rst_perr", perr_a, 0);
      chk("rst_b_in_ready", rdy_b, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_release_ready", rdy_a, 1);

      // Single transfer, receiver echoes after 3 cycles
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         va = tbl[i].v; da = tbl[i].d; acka = tbl[i].ack;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_in_ready", i), rdy_a, tbl[i].rdy);
         chk($sformatf("vec%0d_busy", i), busy_a, tbl[i].bsy);
         chk($sformatf("vec%0d_done", i), done_a, tbl[i].dn);
         chk($sformatf("vec%0d_req", i), req_a, tbl[i].req);
         chk($sformatf("vec%0d_dout", i), dout_a, tbl[i].dout);
      end
      chk("single_perr", perr_a, 0);

      // Back-to-back, in_valid held high
      do_reset();
      bad = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         da = 8'(k); va = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("b2b%0d_req", k), req_a, k % 2);
         chk($sformatf("b2b%0d_dout", k), dout_a, k);
         chk($sformatf("b2b%0d_busy", k), busy_a, 1);
         @(negedge clk);
         da = 8'hEE;
         @(negedge clk);
         @(negedge clk);
         acka = req_a;
         got = 0;
         for (int c = 0; c < 12 && got == 0; c++) begin
            @(posedge clk);
            #1;
            if (dout_a !== 8'(k)) bad++;
            if (rdy_a) got = 1;
         end
         chk($sformatf("b2b%0d_ready", k), got, 1);
         chk($sformatf("b2b%0d_done", k), done_a, 1);
         if (k == 4) va = 1'b0;
      end
      chk("b2b_stable", bad, 0);
      chk("b2b_final_req", req_a, 0);
      chk("b2b_perr", perr_a, 0);

      // Timeout with no ack
      do_reset();
      @(negedge clk);
      da = 8'h77; va = 1'b1;
      @(posedge clk);
      #1;
      chk("to_busy_acc", busy_a, 1);
      @(negedge clk);
      va = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("to_terr_early", terr_a, 0);
      @(posedge clk);
      #1;
      chk("to_terr_set", terr_a, 1);
      chk("to_busy_held", busy_a, 1);
      @(negedge clk);
      acka = req_a;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
         @(posedge clk);
         #1;
         if (done_a) got = 1;
      end
      chk("to_done", got, 1);
      chk("to_terr_sticky", terr_a, 1);
      @(negedge clk);
      ecla = 1'b1;
      @(posedge clk);
      #1;
      chk("to_terr_clear", terr_a, 0);
      @(negedge clk);
      ecla = 1'b0;

      // Protocol error: ack toggles with nothing outstanding
      do_reset();
      @(negedge clk);
      acka = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("pe_early", perr_a, 0);
      @(posedge clk);
      #1;
      chk("pe_set", perr_a, 1);
      @(negedge clk);
      ecla = 1'b1;
      @(posedge clk);
      #1;
      chk("pe_set_wins", perr_a, 1);
      @(negedge clk);
      ecla = 1'b0; acka = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ecla = 1'b1;
      @(posedge clk);
      #1;
      chk("pe_clear", perr_a, 0);
      @(negedge clk);
      ecla = 1'b0;

      // Reset during WAIT
      do_reset();
      @(negedge clk);
      da = 8'h3C; va = 1'b1;
      @(posedge clk);
      #1;
      chk("rm_req", req_a, 1);
      chk("rm_dout", dout_a, 8'h3C);
      @(negedge clk);
      va = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rm_req_rst", req_a, 0);
      chk("rm_dout_rst", dout_a, 0);
      chk("rm_busy_rst", busy_a, 0);
      chk("rm_ready_rst", rdy_a, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rm_ready_rel", rdy_a, 1);
      @(negedge clk);
      da = 8'h5A; va = 1'b1;
      @(posedge clk);
      #1;
      chk("rm_new_req", req_a, 1);
      chk("rm_new_dout", dout_a, 8'h5A);
      @(negedge clk);
      va = 1'b0; acka = 1'b1;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
         @(posedge clk);
         #1;
         if (done_a) got = 1;
      end
      chk("rm_new_done", got, 1);
      chk("rm_new_ready", rdy_a, 1);
      chk("rm_new_perr", perr_a, 0);

      // SyncStages=4: ready returns 5 edges after ack changes
      do_reset();
      @(negedge clk);
      db = 8'hA5; vb = 1'b1;
      @(posedge clk);
      #1;
      chk("ss4_req", req_b, 1);
      chk("ss4_dout", dout_b, 8'hA5);
      @(negedge clk);
      vb = 1'b0;
      repeat (2) @(negedge clk);
      ackb = 1'b1;
      edges = 0; got = 0;
      for (int c = 0; c < 12 && got == 0; c++) begin
         @(posedge clk);
         #1;
         edges++;
         if (rdy_b) got = 1;
      end
      chk("ss4_ready_edges", edges, 5);
      chk("ss4_done", done_b, 1);
      chk("ss4_perr", perr_b, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
